// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer controller of the async FIFO.
// Binary/Gray write pointers, full/almost-full, occupancy, overflow.
module fifo_wr_ctrl #(
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int AF_THRESHOLD = 6
) (
   input  logic                  W_CLK,
   input  logic                  W_RST,
   input  logic                  W_INC,
   input  logic                  OVF_CLR,
   input  logic [ADDR_WIDTH:0]   R_PTR,
   output logic [ADDR_WIDTH:0]   GREY_W_PTR,
   output logic [ADDR_WIDTH-1:0] WR_ADDR,
   output logic                  W_CLKEN,
   output logic                  FULL,
   output logic                  ALMOST_FULL,
   output logic [ADDR_WIDTH:0]   WR_COUNT,
   output logic                  OVERFLOW
);

   localparam int PW = ADDR_WIDTH + 1;

   // Threshold is clamped to the depth so an out-of-range value
   // still yields a flag that can assert.
   localparam int AF_CLAMP =
      (AF_THRESHOLD > FIFO_DEPTH) ? FIFO_DEPTH : AF_THRESHOLD;
   localparam logic [PW-1:0] AF_TH = PW'(AF_CLAMP);

   // Gray full pattern: the two MSBs inverted, the rest equal.
   localparam logic [PW-1:0] FULL_MASK =
      PW'(3) << (ADDR_WIDTH - 1);

   logic [PW-1:0] r_w_bin;
   logic [PW-1:0] r_w_gray;
   logic          r_ovf;

   logic [PW-1:0] w_next_bin;
   logic [PW-1:0] w_next_gray;
   logic [PW-1:0] w_r_bin;
   logic [PW-1:0] w_count;
   logic          w_full;
   logic          w_accept;
   logic          w_reject;

   // Prefix XOR from the MSB down.
   function automatic logic [PW-1:0] gray2bin(
      input logic [PW-1:0] g
   );
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Next-pointer, full test and occupancy from the synced read pointer.
   always_comb begin
      w_next_bin  = r_w_bin + PW'(1);
      w_next_gray = w_next_bin ^ (w_next_bin >> 1);
      w_full      = (r_w_gray == (R_PTR ^ FULL_MASK));
      w_accept    = W_INC & ~w_full;
      w_reject    = W_INC & w_full;
      w_r_bin     = gray2bin(R_PTR);
      w_count     = r_w_bin - w_r_bin;
   end

   // Pointer advance; Gray is a flop so the exported pointer is glitch-free.
   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         r_w_bin  <= '0;
         r_w_gray <= '0;
      end else if (w_accept) begin
         r_w_bin  <= w_next_bin;
         r_w_gray <= w_next_gray;
      end
   end

   // Sticky overflow; a rejected write wins over a same-edge clear.
   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         r_ovf <= 1'b0;
      end else if (w_reject) begin
         r_ovf <= 1'b1;
      end else if (OVF_CLR) begin
         r_ovf <= 1'b0;
      end
   end

   assign GREY_W_PTR  = r_w_gray;
   assign WR_ADDR     = r_w_bin[ADDR_WIDTH-1:0];
   assign W_CLKEN     = w_accept;
   assign FULL        = w_full;
   assign WR_COUNT    = w_count;
   assign ALMOST_FULL = (w_count >= AF_TH);
   assign OVERFLOW    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl.
// Hand-computed vectors: reset, fill, overflow, drain, wrap, count.
module tb_fifo_wr_ctrl;

   logic       W_CLK = 1'b0;
   logic       W_RST;
   logic       W_INC;
   logic       OVF_CLR;
   logic [3:0] R_PTR;
   logic [3:0] GREY_W_PTR;
   logic [2:0] WR_ADDR;
   logic       W_CLKEN;
   logic       FULL;
   logic       ALMOST_FULL;
   logic [3:0] WR_COUNT;
   logic       OVERFLOW;

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] mb;
   logic [3:0] mg;
   logic [3:0] pg;

   fifo_wr_ctrl #(
      .FIFO_DEPTH(8),
      .ADDR_WIDTH(3),
      .AF_THRESHOLD(6)
   ) dut (
      .W_CLK(W_CLK),
      .W_RST(W_RST),
      .W_INC(W_INC),
      .OVF_CLR(OVF_CLR),
      .R_PTR(R_PTR),
      .GREY_W_PTR(GREY_W_PTR),
      .WR_ADDR(WR_ADDR),
      .W_CLKEN(W_CLKEN),
      .FULL(FULL),
      .ALMOST_FULL(ALMOST_FULL),
      .WR_COUNT(WR_COUNT),
      .OVERFLOW(OVERFLOW)
   );

   always #5 W_CLK = ~W_CLK;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge W_CLK);
      #1;
   endtask

   task automatic do_rst();
      W_RST   = 1'b0;
      W_INC   = 1'b0;
      OVF_CLR = 1'b0;
      R_PTR   = 4'b0000;
      #1;
      tick();
      W_RST = 1'b1;
   endtask

   initial begin
      W_RST   = 1'b0;
      W_INC   = 1'b0;
      OVF_CLR = 1'b0;
      R_PTR   = 4'b0000;
      #2;
      chk("rst_gry", 32'(GREY_W_PTR), 32'h0);
      chk("rst_adr", 32'(WR_ADDR), 32'h0);
      chk("rst_full", 32'(FULL), 32'h0);
      chk("rst_af", 32'(ALMOST_FULL), 32'h0);
      chk("rst_cnt", 32'(WR_COUNT), 32'h0);
      chk("rst_ovf", 32'(OVERFLOW), 32'h0);
      chk("rst_en0", 32'(W_CLKEN), 32'h0);
      W_INC = 1'b1;
      #1;
      chk("rst_en1", 32'(W_CLKEN), 32'h1);
      W_INC = 1'b0;
      tick();
      W_RST = 1'b1;
      tick();

      // mid-stream asynchronous reset at W_BIN=5
      W_INC = 1'b1;
      repeat (5) tick();
      chk("mid_adr5", 32'(WR_ADDR), 32'h5);
      chk("mid_cnt5", 32'(WR_COUNT), 32'h5);
      W_INC = 1'b0;
      #2;
      W_RST = 1'b0;
      #1;
      chk("mid_gry", 32'(GREY_W_PTR), 32'h0);
      chk("mid_adr", 32'(WR_ADDR), 32'h0);
      chk("mid_cnt", 32'(WR_COUNT), 32'h0);
      tick();
      W_RST = 1'b1;
      W_INC = 1'b1;
      #1;
      chk("rel_adr", 32'(WR_ADDR), 32'h0);
      chk("rel_en", 32'(W_CLKEN), 32'h1);
      tick();
      chk("rel_adr1", 32'(WR_ADDR), 32'h1);
      chk("rel_gry", 32'(GREY_W_PTR), 32'h1);

      // fill with R_PTR=0
      do_rst();
      mb = 4'd0;
      W_INC = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("fill_adr", 32'(WR_ADDR), 32'(mb[2:0]));
         chk("fill_en", 32'(W_CLKEN), 32'h1);
         tick();
         mb = mb + 4'd1;
         mg = mb ^ (mb >> 1);
         chk("fill_gry", 32'(GREY_W_PTR), 32'(mg));
         chk("fill_cnt", 32'(WR_COUNT), 32'(mb));
         chk("fill_af", 32'(ALMOST_FULL), 32'(mb >= 4'd6));
         chk("fill_full", 32'(FULL), 32'(mb == 4'd8));
      end
      chk("fill_last", 32'(GREY_W_PTR), 32'hC);

      // overflow while full
      chk("ovf_en", 32'(W_CLKEN), 32'h0);
      repeat (2) tick();
      chk("ovf_adr", 32'(WR_ADDR), 32'h0);
      chk("ovf_gry", 32'(GREY_W_PTR), 32'hC);
      chk("ovf_cnt", 32'(WR_COUNT), 32'h8);
      chk("ovf_set", 32'(OVERFLOW), 32'h1);
      W_INC   = 1'b0;
      OVF_CLR = 1'b1;
      tick();
      chk("ovf_clr", 32'(OVERFLOW), 32'h0);
      W_INC = 1'b1;
      tick();
      chk("ovf_prio", 32'(OVERFLOW), 32'h1);
      chk("ovf_gry2", 32'(GREY_W_PTR), 32'hC);
      OVF_CLR = 1'b0;
      W_INC   = 1'b0;

      // drain release
      R_PTR = 4'b0001;
      #1;
      chk("drn_full", 32'(FULL), 32'h0);
      chk("drn_cnt", 32'(WR_COUNT), 32'h7);
      chk("drn_af", 32'(ALMOST_FULL), 32'h1);
      W_INC = 1'b1;
      #1;
      chk("drn_adr", 32'(WR_ADDR), 32'h0);
      chk("drn_en", 32'(W_CLKEN), 32'h1);
      tick();
      W_INC = 1'b0;
      chk("drn_gry", 32'(GREY_W_PTR), 32'hD);
      chk("drn_cnt8", 32'(WR_COUNT), 32'h8);
      chk("drn_full8", 32'(FULL), 32'h1);

      // wrap with R_PTR trailing the write pointer
      do_rst();
      mb = 4'd0;
      mg = 4'd0;
      W_INC = 1'b1;
      for (int i = 0; i < 16; i++) begin
         R_PTR = mg;
         #1;
         chk("wrap_full", 32'(FULL), 32'h0);
         pg = mg;
         tick();
         mb = mb + 4'd1;
         mg = mb ^ (mb >> 1);
         chk("wrap_gry", 32'(GREY_W_PTR), 32'(mg));
         chk("wrap_1bit", 32'($countones(GREY_W_PTR ^ pg)), 32'h1);
      end
      W_INC = 1'b0;
      chk("wrap_end", 32'(GREY_W_PTR), 32'h0);

      // occupancy across pointer wrap
      do_rst();
      W_INC = 1'b1;
      repeat (2) tick();
      W_INC = 1'b0;
      chk("cw_gry", 32'(GREY_W_PTR), 32'h3);
      R_PTR = 4'b1011;
      #1;
      chk("cw_cnt", 32'(WR_COUNT), 32'h5);
      chk("cw_full", 32'(FULL), 32'h0);
      chk("cw_af", 32'(ALMOST_FULL), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
